eth_rx_mac: RTL and testbench

ETH_RX_MAC -- requirements
Module: eth_rx_mac

---
 rtl/eth_rx_mac.sv | 171 +++++++++++++++++
 tb/tb_eth_rx_mac.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_mac.sv
// GMII receive MAC: strips preamble/SFD and FCS, checks CRC-32, length and rx_er,
// and streams frame bytes out with a per-frame bad flag on the tlast beat.
module eth_rx_mac #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        gmii_rx_clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_er,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [31:0] stat_good_frames,
    output logic [31:0] stat_bad_frames
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [31:0] MIN_LEN_U   = 32'(MIN_LEN);
    localparam logic [31:0] MAX_LEN_U   = 32'(MAX_LEN);
    localparam int          DLY_DEPTH   = 5;

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [10:0] cnt_q, cnt_d;
    logic        er_seen_q, er_seen_d;
    logic        armed_q, armed_d;
    logic [7:0]  tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic [31:0] good_q, good_d;
    logic [31:0] bad_q, bad_d;
    logic        shift_en;
    logic        frame_bad;
    logic [31:0] len_w;
    logic [7:0]  dly_q [DLY_DEPTH];

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Stage 0 takes the newest byte; the last stage holds the byte awaiting output.
    generate
        for (genvar gi = 0; gi < DLY_DEPTH; gi++) begin : g_dly
            if (gi == 0) begin : g_head
                always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
                    if (!rst_n)        dly_q[gi] <= 8'h00;
                    else if (shift_en) dly_q[gi] <= gmii_rxd;
                end
            end else begin : g_tail
                always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
                    if (!rst_n)        dly_q[gi] <= 8'h00;
                    else if (shift_en) dly_q[gi] <= dly_q[gi-1];
                end
            end
        end
    endgenerate

    assign len_w = {21'd0, cnt_q};

    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            crc_q     <= CRC_INIT;
            cnt_q     <= 11'd0;
            er_seen_q <= 1'b0;
            armed_q   <= 1'b0;
            tdata_q   <= 8'h00;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            good_q    <= 32'd0;
            bad_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            cnt_q     <= cnt_d;
            er_seen_q <= er_seen_d;
            armed_q   <= armed_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        cnt_d     = cnt_q;
        er_seen_d = er_seen_q;
        // A frame may only start once dv has been seen low since reset.
        armed_d   = armed_q | ~gmii_rx_dv;
        tdata_d   = 8'h00;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        tuser_d   = 1'b0;
        good_d    = good_q;
        bad_d     = bad_q;
        shift_en  = 1'b0;
        frame_bad = er_seen_q || (crc_q != CRC_RESIDUE) || (cnt_q < 11'd5) ||
                    (len_w < MIN_LEN_U) || (len_w > MAX_LEN_U);
        unique case (state_q)
            IDLE: begin
                if (gmii_rx_dv) begin
                    state_d = (gmii_rxd == 8'h55 && armed_q) ? PREAMBLE : DISCARD;
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_d = IDLE;
                end else if (gmii_rxd == 8'hD5) begin
                    state_d   = DATA;
                    crc_d     = CRC_INIT;
                    cnt_d     = 11'd0;
                    er_seen_d = 1'b0;
                end else if (gmii_rxd != 8'h55) begin
                    state_d = DISCARD;
                end
            end
            DATA: begin
                if (gmii_rx_dv) begin
                    shift_en  = 1'b1;
                    crc_d     = crc_next(crc_q, gmii_rxd);
                    cnt_d     = (cnt_q == 11'h7FF) ? cnt_q : cnt_q + 11'd1;
                    er_seen_d = er_seen_q | gmii_rx_er;
                    if (cnt_q >= 11'd5) begin
                        tvalid_d = 1'b1;
                        tdata_d  = dly_q[DLY_DEPTH-1];
                    end
                end else begin
                    state_d = IDLE;
                    if (cnt_q >= 11'd5) begin
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tuser_d  = frame_bad;
                        tdata_d  = dly_q[DLY_DEPTH-1];
                    end
                    if (frame_bad) bad_d  = bad_q + 32'd1;
                    else           good_d = good_q + 32'd1;
                end
            end
            DISCARD: begin
                if (!gmii_rx_dv) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_axis_tdata     = tdata_q;
    assign m_axis_tvalid    = tvalid_q;
    assign m_axis_tlast     = tlast_q;
    assign m_axis_tuser     = tuser_q;
    assign stat_good_frames = good_q;
    assign stat_bad_frames  = bad_q;

endmodule

// File: tb/tb_eth_rx_mac.sv
// Randomised bench for eth_rx_mac: a frame-level model predicts beats and counters
// into a queue that an independent monitor drains as the DUT emits beats.
module tb_eth_rx_mac;

    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 160;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0;
    logic        er = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic [7:0]  tdata;
    logic        tvalid, tlast, tuser;
    logic [31:0] stat_good, stat_bad;

    eth_rx_mac #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
        .gmii_rx_clk      (clk),
        .rst_n            (rst_n),
        .gmii_rx_dv       (dv),
        .gmii_rxd         (rxd),
        .gmii_rx_er       (er),
        .m_axis_tdata     (tdata),
        .m_axis_tvalid    (tvalid),
        .m_axis_tlast     (tlast),
        .m_axis_tuser     (tuser),
        .stat_good_frames (stat_good),
        .stat_bad_frames  (stat_bad)
    );

    always #4 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        last;
        logic        user;
        logic [31:0] good;
        logic [31:0] bad;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  pre_q[$];
    logic [7:0]  dat_q[$];
    bit          er_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_good = 0;
    logic [31:0] exp_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input logic [7:0] d, input logic l, input logic u);
        beat_t b;
        b.data = d; b.last = l; b.user = u; b.good = exp_good; b.bad = exp_bad;
        exp_q.push_back(b);
    endtask

    // Ethernet FCS value over the first n bytes of dat_q (final complement applied).
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        logic        fb;
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ dat_q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic std_pre();
        pre_q.delete();
        for (int i = 0; i < 7; i++) pre_q.push_back(8'h55);
        pre_q.push_back(8'hD5);
    endtask

    task automatic build(input int payload_n, input bit corrupt, input int er_idx);
        logic [31:0] f;
        dat_q.delete(); er_q.delete();
        for (int i = 0; i < payload_n; i++) dat_q.push_back(8'($urandom_range(0, 255)));
        f = fcs_of(payload_n);
        dat_q.push_back(f[7:0]);   dat_q.push_back(f[15:8]);
        dat_q.push_back(f[23:16]); dat_q.push_back(f[31:24]);
        if (corrupt) dat_q[dat_q.size()-1] = dat_q[dat_q.size()-1] ^ 8'h01;
        for (int i = 0; i < dat_q.size(); i++) er_q.push_back(i == er_idx);
    endtask

    task automatic build_raw(input int n);
        dat_q.delete(); er_q.delete();
        for (int i = 0; i < n; i++) begin
            dat_q.push_back(8'($urandom_range(0, 255)));
            er_q.push_back(1'b0);
        end
    endtask

    // Frame-level prediction: preamble legality, FCS/length/error verdict, beats.
    task automatic model_frame();
        bit          pre_ok, bad;
        int          n;
        logic [31:0] got_fcs;
        pre_ok = (pre_q.size() >= 2) && (pre_q[pre_q.size()-1] == 8'hD5);
        for (int i = 0; i < pre_q.size() - 1; i++) if (pre_q[i] != 8'h55) pre_ok = 0;
        if (!pre_ok) return;
        n   = dat_q.size();
        bad = (n < 5) || (n < MIN_LEN) || (n > MAX_LEN);
        foreach (er_q[i]) if (er_q[i]) bad = 1;
        if (n >= 4) begin
            got_fcs = {dat_q[n-1], dat_q[n-2], dat_q[n-3], dat_q[n-4]};
            if (got_fcs != fcs_of(n - 4)) bad = 1;
        end
        if (bad) exp_bad++; else exp_good++;
        for (int i = 0; i <= n - 5; i++) push_beat(dat_q[i], i == n - 5, (i == n - 5) ? bad : 1'b0);
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic e);
        @(negedge clk);
        dv = 1'b1; rxd = d; er = e;
    endtask

    task automatic drive_frame(input int gap);
        foreach (pre_q[i]) drive_byte(pre_q[i], 1'b0);
        foreach (dat_q[i]) drive_byte(dat_q[i], er_q[i]);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            dv = 1'b0; rxd = 8'($urandom_range(0, 255)); er = 1'($urandom_range(0, 1));
        end
        if (gap >= 2) begin
            check("stat_good", stat_good, exp_good);
            check("stat_bad", stat_bad, exp_bad);
        end
    endtask

    task automatic run_frame(input int gap);
        model_frame();
        drive_frame(gap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tdata"}, {24'd0, tdata}, 32'd0);
        check({tag, "_tvalid"}, {31'd0, tvalid}, 32'd0);
        check({tag, "_tlast"}, {31'd0, tlast}, 32'd0);
        check({tag, "_tuser"}, {31'd0, tuser}, 32'd0);
        check({tag, "_good"}, stat_good, 32'd0);
        check({tag, "_bad"}, stat_bad, 32'd0);
    endtask

    // Monitor: every beat the DUT presents is compared against the head of the queue.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n && tvalid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    b = exp_q.pop_front();
                    check("tdata", {24'd0, tdata}, {24'd0, b.data});
                    check("tlast", {31'd0, tlast}, {31'd0, b.last});
                    check("tuser", {31'd0, tuser}, {31'd0, b.user});
                    if (b.last) begin
                        check("tlast_good", stat_good, b.good);
                        check("tlast_bad", stat_bad, b.bad);
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cyc;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Good, bad-FCS and rx_er 64-byte frames.
        std_pre(); build(60, 0, -1); run_frame(3);
        std_pre(); build(60, 1, -1); run_frame(3);
        std_pre(); build(60, 0, 20); run_frame(3);
        // Runt with beats, then a 3-byte frame with none.
        std_pre(); build(36, 0, -1); run_frame(3);
        std_pre(); build_raw(3);     run_frame(3);
        // Length boundaries and the smallest frame that yields a beat.
        std_pre(); build(59, 0, -1);  run_frame(3);
        std_pre(); build(60, 0, -1);  run_frame(3);
        std_pre(); build(156, 0, -1); run_frame(3);
        std_pre(); build(157, 0, -1); run_frame(3);
        std_pre(); build(1, 0, -1);   run_frame(3);
        // Broken preamble is discarded; the next frame is still received.
        pre_q = '{8'h55, 8'h55, 8'h57}; build(60, 0, -1); run_frame(3);
        std_pre(); build(60, 0, -1); run_frame(3);
        // Back-to-back frames separated by a single dv-low cycle.
        std_pre(); build(70, 0, -1); run_frame(1);
        std_pre(); build(64, 0, -1); run_frame(1);
        std_pre(); build(61, 1, -1); run_frame(3);
        // Long frame that saturates the byte counter.
        std_pre(); build(2096, 0, -1); run_frame(3);

        // Reset mid-frame at data byte 30, released while dv is still high.
        std_pre(); build(60, 0, -1);
        for (int i = 0; i < 25; i++) push_beat(dat_q[i], 1'b0, 1'b0);
        foreach (pre_q[i]) drive_byte(pre_q[i], 1'b0);
        for (int i = 0; i < 30; i++) drive_byte(dat_q[i], 1'b0);
        @(negedge clk);
        dv = 1'b1; rxd = dat_q[30];
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        exp_good = 0; exp_bad = 0;
        drive_byte(dat_q[31], 1'b0);
        drive_byte(dat_q[32], 1'b0);
        check("beats_before_reset", exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rxd = dat_q[33];
        #2 rst_n = 1'b1;
        pre_q = '{8'h55, 8'h55, 8'h55, 8'hD5};
        foreach (pre_q[i]) drive_byte(pre_q[i], 1'b0);
        for (int i = 0; i < 20; i++) drive_byte(dat_q[i], 1'b0);
        @(negedge clk); dv = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_good", stat_good, 32'd0);
        check("post_reset_bad", stat_bad, 32'd0);
        std_pre(); build(60, 0, -1); run_frame(3);

        // Randomised frames.
        for (int f = 0; f < 25; f++) begin
            int plen;
            plen = $urandom_range(1, 8);
            pre_q.delete();
            for (int i = 0; i < plen; i++) pre_q.push_back(8'h55);
            pre_q.push_back(8'hD5);
            if ($urandom_range(0, 9) == 0) begin
                logic [7:0] x;
                x = 8'($urandom_range(0, 255));
                if (x == 8'h55 || x == 8'hD5) x = 8'hAA;
                pre_q[$urandom_range(0, plen - 1)] = x;
            end
            if ($urandom_range(0, 9) == 0) build_raw($urandom_range(1, 4));
            else build($urandom_range(0, 200), $urandom_range(0, 4) == 0,
                       ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40) : -1);
            run_frame($urandom_range(1, 4));
        end

        @(negedge clk); dv = 1'b0;
        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("missing_beats", exp_q.size(), 32'd0);
        check("final_good", stat_good, exp_good);
        check("final_bad", stat_bad, exp_bad);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
